// File: rtl/fft_iter.sv
`default_nettype none
// ============================================================================
// Module   : fft_iter
// Brief    : iterative in-place radix-2 DIT FFT, one butterfly per clock
// Revision : 1.0
// ============================================================================
module fft_iter #(
    parameter int DATA_W = 32,
    parameter int LOG2N  = 3,
    parameter int SCALE  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_re,
    output logic [DATA_W-1:0] out_im,
    output logic              out_last,
    output logic              busy
);

    localparam int                 c_N         = 1 << LOG2N;
    localparam int                 c_STG_W     = 3;
    localparam int                 c_PW        = DATA_W + 19;
    localparam logic [LOG2N-1:0]   c_LAST_IDX  = LOG2N'(c_N - 1);
    localparam logic [LOG2N-1:0]   c_LAST_BFLY = LOG2N'(c_N / 2 - 1);
    localparam logic [c_STG_W-1:0] c_LAST_STG  = c_STG_W'(LOG2N - 1);

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_COMPUTE = 2'd1,
        S_UNLOAD  = 2'd2
    } state_t;

    state_t               r_state, w_state_next;
    logic [LOG2N-1:0]     r_cnt, w_cnt_next;
    logic [LOG2N-1:0]     r_bfly, w_bfly_next;
    logic [c_STG_W-1:0]   r_stage, w_stage_next;
    logic                 w_bfly_en;
    logic                 w_in_fire;
    logic                 w_out_fire;

    logic signed [DATA_W-1:0] r_mem_re [c_N];
    logic signed [DATA_W-1:0] r_mem_im [c_N];

    logic [LOG2N-1:0]     w_half, w_pos, w_top, w_bot;
    logic [5:0]           w_rom_idx;
    logic [4:0]           w_j, w_jc;
    logic signed [17:0]   w_tw_re, w_tw_im;

    logic signed [DATA_W-1:0] w_a_re, w_a_im, w_b_re, w_b_im;
    logic signed [c_PW-1:0]   w_br_x, w_bi_x, w_wr_x, w_wi_x;
    logic signed [c_PW-1:0]   w_pr_full, w_pi_full;
    logic signed [DATA_W-1:0] w_pr, w_pi;
    logic signed [DATA_W:0]   w_add_re, w_add_im, w_sub_re, w_sub_im;
    logic [DATA_W-1:0]        w_top_re, w_top_im, w_bot_re, w_bot_im;
    logic                     w_unused_prod;

    function automatic logic [LOG2N-1:0] f_bitrev(input logic [LOG2N-1:0] n);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = n[LOG2N-1-i];
        end
        return r;
    endfunction

    // Quarter-wave cosine, trunc-toward-zero(65536*cos(2*pi*i/64)), i = 0..16
    function automatic logic signed [17:0] f_cos_q(input logic [4:0] i);
        case (i)
            5'd0:    return 18'sd65536;
            5'd1:    return 18'sd65220;
            5'd2:    return 18'sd64276;
            5'd3:    return 18'sd62714;
            5'd4:    return 18'sd60547;
            5'd5:    return 18'sd57797;
            5'd6:    return 18'sd54491;
            5'd7:    return 18'sd50660;
            5'd8:    return 18'sd46340;
            5'd9:    return 18'sd41575;
            5'd10:   return 18'sd36409;
            5'd11:   return 18'sd30893;
            5'd12:   return 18'sd25079;
            5'd13:   return 18'sd19024;
            5'd14:   return 18'sd12785;
            5'd15:   return 18'sd6423;
            default: return 18'sd0;
        endcase
    endfunction

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = (r_state == S_UNLOAD) & out_ready;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_bfly_next  = r_bfly;
        w_stage_next = r_stage;
        w_bfly_en    = 1'b0;
        case (r_state)
            S_LOAD: begin
                if (w_in_fire) begin
                    w_cnt_next = r_cnt + 1'b1;
                    if (r_cnt == c_LAST_IDX) begin
                        w_cnt_next   = '0;
                        w_state_next = S_COMPUTE;
                    end
                end
            end
            S_COMPUTE: begin
                w_bfly_en   = 1'b1;
                w_bfly_next = r_bfly + 1'b1;
                if (r_bfly == c_LAST_BFLY) begin
                    w_bfly_next  = '0;
                    w_stage_next = r_stage + 1'b1;
                    if (r_stage == c_LAST_STG) begin
                        w_stage_next = '0;
                        w_state_next = S_UNLOAD;
                    end
                end
            end
            S_UNLOAD: begin
                if (w_out_fire) begin
                    w_cnt_next = r_cnt + 1'b1;
                    if (r_cnt == c_LAST_IDX) begin
                        w_cnt_next   = '0;
                        w_state_next = S_LOAD;
                    end
                end
            end
            default: w_state_next = S_LOAD;
        endcase
    end

    // in_ready is registered so it stays low through the reset cycles themselves
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_LOAD;
            r_cnt    <= '0;
            r_bfly   <= '0;
            r_stage  <= '0;
            in_ready <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_bfly   <= w_bfly_next;
            r_stage  <= w_stage_next;
            in_ready <= (w_state_next == S_LOAD);
        end
    end

    assign w_half    = LOG2N'(1) << r_stage;
    assign w_pos     = r_bfly & (w_half - LOG2N'(1));
    assign w_top     = ((r_bfly >> r_stage) << (r_stage + 3'd1)) | w_pos;
    assign w_bot     = w_top | w_half;
    assign w_rom_idx = 6'(w_pos) << (3'd5 - r_stage);

    // Full 64-entry twiddle table folded onto one quarter wave by symmetry
    assign w_j  = {1'b0, w_rom_idx[3:0]};
    assign w_jc = 5'd16 - w_j;

    always_comb begin
        w_tw_re = '0;
        w_tw_im = '0;
        case (w_rom_idx[5:4])
            2'd0: begin w_tw_re =  f_cos_q(w_j);  w_tw_im = -f_cos_q(w_jc); end
            2'd1: begin w_tw_re = -f_cos_q(w_jc); w_tw_im = -f_cos_q(w_j);  end
            2'd2: begin w_tw_re = -f_cos_q(w_j);  w_tw_im =  f_cos_q(w_jc); end
            default: begin w_tw_re = f_cos_q(w_jc); w_tw_im = f_cos_q(w_j); end
        endcase
    end

    assign w_a_re = r_mem_re[w_top];
    assign w_a_im = r_mem_im[w_top];
    assign w_b_re = r_mem_re[w_bot];
    assign w_b_im = r_mem_im[w_bot];

    assign w_br_x = c_PW'(w_b_re);
    assign w_bi_x = c_PW'(w_b_im);
    assign w_wr_x = c_PW'(w_tw_re);
    assign w_wi_x = c_PW'(w_tw_im);

    assign w_pr_full = w_br_x * w_wr_x - w_bi_x * w_wi_x;
    assign w_pi_full = w_br_x * w_wi_x + w_bi_x * w_wr_x;
    assign w_pr      = w_pr_full[DATA_W+15:16];
    assign w_pi      = w_pi_full[DATA_W+15:16];
    assign w_unused_prod = ^{w_pr_full[c_PW-1:DATA_W+16], w_pr_full[15:0],
                             w_pi_full[c_PW-1:DATA_W+16], w_pi_full[15:0]};

    assign w_add_re = {w_a_re[DATA_W-1], w_a_re} + {w_pr[DATA_W-1], w_pr};
    assign w_add_im = {w_a_im[DATA_W-1], w_a_im} + {w_pi[DATA_W-1], w_pi};
    assign w_sub_re = {w_a_re[DATA_W-1], w_a_re} - {w_pr[DATA_W-1], w_pr};
    assign w_sub_im = {w_a_im[DATA_W-1], w_a_im} - {w_pi[DATA_W-1], w_pi};

    generate
        if (SCALE != 0) begin : g_scale
            logic w_unused_lsb;
            assign w_top_re = w_add_re[DATA_W:1];
            assign w_top_im = w_add_im[DATA_W:1];
            assign w_bot_re = w_sub_re[DATA_W:1];
            assign w_bot_im = w_sub_im[DATA_W:1];
            assign w_unused_lsb = w_add_re[0] ^ w_add_im[0] ^ w_sub_re[0] ^ w_sub_im[0];
        end else begin : g_noscale
            logic w_unused_msb;
            assign w_top_re = w_add_re[DATA_W-1:0];
            assign w_top_im = w_add_im[DATA_W-1:0];
            assign w_bot_re = w_sub_re[DATA_W-1:0];
            assign w_bot_im = w_sub_im[DATA_W-1:0];
            assign w_unused_msb = w_add_re[DATA_W] ^ w_add_im[DATA_W]
                                ^ w_sub_re[DATA_W] ^ w_sub_im[DATA_W];
        end
    endgenerate

    // Sample array holds no reset; a new frame overwrites every address
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_in_fire) begin
                r_mem_re[f_bitrev(r_cnt)] <= in_re;
                r_mem_im[f_bitrev(r_cnt)] <= in_im;
            end else if (w_bfly_en) begin
                r_mem_re[w_top] <= w_top_re;
                r_mem_im[w_top] <= w_top_im;
                r_mem_re[w_bot] <= w_bot_re;
                r_mem_im[w_bot] <= w_bot_im;
            end
        end
    end

    assign out_valid = (r_state == S_UNLOAD);
    assign busy      = (r_state != S_LOAD);
    assign out_last  = out_valid && (r_cnt == c_LAST_IDX);
    assign out_re    = out_valid ? r_mem_re[r_cnt] : '0;
    assign out_im    = out_valid ? r_mem_im[r_cnt] : '0;

endmodule
`default_nettype wire

// File: tb/tb_fft_iter.sv
`default_nettype none
// Bench for fft_iter: directed spectra plus random frames scored against a
// stage-by-stage fixed-point reference whose twiddles come from real-valued cos/sin.
module tb_fft_iter;

    localparam int  DW = 32;
    localparam real PI = 3.14159265358979323846;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    in_valid, in_ready, out_valid, out_last, busy;
    logic [DW-1:0] in_re, in_im;
    logic          out_ready;
    logic [DW-1:0] out_re [4];
    logic [DW-1:0] out_im [4];

    int vectors     = 0;
    int miscompares = 0;

    int            x_re   [64];
    int            x_im   [64];
    int            exp_re [64];
    int            exp_im [64];
    logic [DW-1:0] got_re [64];
    logic [DW-1:0] got_im [64];

    always #5 clk = ~clk;

    fft_iter #(.DATA_W(DW), .LOG2N(3), .SCALE(0)) u_n8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_re(in_re), .in_im(in_im), .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_re(out_re[0]), .out_im(out_im[0]), .out_last(out_last[0]), .busy(busy[0]));

    fft_iter #(.DATA_W(DW), .LOG2N(3), .SCALE(1)) u_n8s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_re(in_re), .in_im(in_im), .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_re(out_re[1]), .out_im(out_im[1]), .out_last(out_last[1]), .busy(busy[1]));

    fft_iter #(.DATA_W(DW), .LOG2N(1), .SCALE(0)) u_n2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_re(in_re), .in_im(in_im), .out_valid(out_valid[2]), .out_ready(out_ready),
        .out_re(out_re[2]), .out_im(out_im[2]), .out_last(out_last[2]), .busy(busy[2]));

    fft_iter #(.DATA_W(DW), .LOG2N(6), .SCALE(0)) u_n64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .in_re(in_re), .in_im(in_im), .out_valid(out_valid[3]), .out_ready(out_ready),
        .out_re(out_re[3]), .out_im(out_im[3]), .out_last(out_last[3]), .busy(busy[3]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: bit-reversed load, then the textbook in-place DIT stages
    task automatic model(input int lg, input int scale);
        int     n, half, pos, top, bot, k, r;
        int     a_re [64];
        int     a_im [64];
        real    ang;
        longint wr, wi, pr, pm, s_re, s_im, d_re, d_im;
        n = 1 << lg;
        for (int i = 0; i < n; i++) begin
            r = 0;
            for (int j = 0; j < lg; j++) if (((i >> j) & 1) == 1) r = r | (1 << (lg - 1 - j));
            a_re[r] = x_re[i];
            a_im[r] = x_im[i];
        end
        for (int s = 0; s < lg; s++) begin
            for (int b = 0; b < n / 2; b++) begin
                half = 1 << s;
                pos  = b % half;
                top  = (b >> s) * 2 * half + pos;
                bot  = top + half;
                k    = pos * (n >> (s + 1));
                ang  = 2.0 * PI * real'(k) / real'(n);
                wr   = longint'($rtoi(65536.0 * $cos(ang)));
                wi   = longint'($rtoi(-65536.0 * $sin(ang)));
                pr   = (longint'(a_re[bot]) * wr - longint'(a_im[bot]) * wi) >>> 16;
                pm   = (longint'(a_re[bot]) * wi + longint'(a_im[bot]) * wr) >>> 16;
                pr   = longint'(int'(pr));
                pm   = longint'(int'(pm));
                s_re = longint'(a_re[top]) + pr;
                s_im = longint'(a_im[top]) + pm;
                d_re = longint'(a_re[top]) - pr;
                d_im = longint'(a_im[top]) - pm;
                if (scale != 0) begin
                    s_re = s_re >>> 1; s_im = s_im >>> 1;
                    d_re = d_re >>> 1; d_im = d_im >>> 1;
                end
                a_re[top] = int'(s_re); a_im[top] = int'(s_im);
                a_re[bot] = int'(d_re); a_im[bot] = int'(d_im);
            end
        end
        for (int i = 0; i < n; i++) begin
            exp_re[i] = a_re[i];
            exp_im[i] = a_im[i];
        end
    endtask

    task automatic fill_x(input int kind);
        for (int i = 0; i < 64; i++) begin
            case (kind)
                0:       begin x_re[i] = (i == 0) ? 32'h10000 : 0; x_im[i] = 0; end
                1:       begin x_re[i] = 32'h10000;                x_im[i] = 0; end
                2:       begin x_re[i] = (i == 1) ? 32'h10000 : 0; x_im[i] = 0; end
                default: begin x_re[i] = int'($urandom);           x_im[i] = int'($urandom); end
            endcase
        end
    endtask

    task automatic send_frame(input int d, input int n, input bit gaps, input string name);
        int sent, guard;
        bit acc;
        sent = 0; guard = 0;
        while (sent < n && guard < 2000) begin
            in_valid[d] = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_re       = x_re[sent];
            in_im       = x_im[sent];
            out_ready   = 1'($urandom_range(0, 1));
            acc         = in_valid[d] && in_ready[d];
            @(posedge clk); #1;
            if (acc) sent++;
            guard++;
        end
        check($sformatf("%s samples accepted", name), sent, n);
    endtask

    task automatic finish_frame(input int d, input int n, input bit gaps, input bit stall,
                                input int exp_cc, input string name);
        int cyc, guard, k, ir_bad, pat;
        bit hold;
        logic [DW-1:0] h_re, h_im;
        logic h_last;
        cyc = 0; guard = 0; ir_bad = 0; hold = 1'b0; h_re = '0; h_im = '0; h_last = 1'b0;
        while (!out_valid[d] && guard < 500) begin
            if (busy[d]) cyc++;
            if (in_ready[d]) ir_bad++;
            in_valid[d] = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
            in_re = $urandom; in_im = $urandom;
            @(posedge clk); #1;
            guard++;
        end
        check($sformatf("%s compute cycles", name), cyc, exp_cc);
        k = 0; guard = 0; pat = 0;
        while (k < n && guard < 2000) begin
            if (!out_valid[d]) begin
                check($sformatf("%s out_valid during unload", name), out_valid[d], 1'b1);
                break;
            end
            if (in_ready[d]) ir_bad++;
            if (hold) begin
                check($sformatf("%s held re", name), out_re[d], h_re);
                check($sformatf("%s held im", name), out_im[d], h_im);
                check($sformatf("%s held last", name), out_last[d], h_last);
            end
            check($sformatf("%s out_last bin%0d", name, k), out_last[d], (k == n - 1));
            out_ready   = stall ? (pat % 3 == 0) : 1'b1;
            in_valid[d] = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
            in_re = $urandom; in_im = $urandom;
            got_re[k] = out_re[d]; got_im[k] = out_im[d];
            hold = !out_ready; h_re = out_re[d]; h_im = out_im[d]; h_last = out_last[d];
            @(posedge clk); #1;
            if (!hold) k++;
            pat++; guard++;
        end
        in_valid[d] = 1'b0;
        check($sformatf("%s bins delivered", name), k, n);
        check($sformatf("%s out_valid after last", name), out_valid[d], 1'b0);
        check($sformatf("%s in_ready after last", name), in_ready[d], 1'b1);
        check($sformatf("%s in_ready high while busy", name), ir_bad, 0);
        out_ready = 1'b0;
    endtask

    task automatic compare_bins(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s bin%0d re", name, i), got_re[i], exp_re[i]);
            check($sformatf("%s bin%0d im", name, i), got_im[i], exp_im[i]);
        end
    endtask

    task automatic dc_expect(input int n, input int bin0);
        for (int i = 0; i < 64; i++) begin
            exp_re[i] = (i == 0) ? bin0 : 0;
            exp_im[i] = 0;
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = '0; out_ready = 1'b0; in_re = '0; in_im = '0;
        repeat (3) @(posedge clk); #1;
        check("reset in_ready", in_ready, 4'h0);
        check("reset out_valid", out_valid, 4'h0);
        check("reset busy", busy, 4'h0);
        check("reset out_last", out_last, 4'h0);
        check("reset out_re", out_re[0], 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready after release", in_ready, 4'hF);

        fill_x(0);
        send_frame(0, 8, 1'b0, "impulse");
        finish_frame(0, 8, 1'b0, 1'b0, 12, "impulse");
        for (int i = 0; i < 8; i++) begin exp_re[i] = 32'h10000; exp_im[i] = 0; end
        compare_bins(8, "impulse");

        fill_x(1);
        send_frame(0, 8, 1'b0, "dc");
        finish_frame(0, 8, 1'b0, 1'b0, 12, "dc");
        dc_expect(8, 32'h80000);
        compare_bins(8, "dc");

        send_frame(1, 8, 1'b0, "dc_scaled");
        finish_frame(1, 8, 1'b0, 1'b0, 12, "dc_scaled");
        dc_expect(8, 32'h10000);
        compare_bins(8, "dc_scaled");

        fill_x(2);
        send_frame(0, 8, 1'b0, "delayed");
        finish_frame(0, 8, 1'b0, 1'b0, 12, "delayed");
        exp_re = '{default: 0}; exp_im = '{default: 0};
        exp_re[0] = 32'h00010000; exp_im[0] = 32'h00000000;
        exp_re[1] = 32'h0000B504; exp_im[1] = 32'hFFFF4AFC;
        exp_re[2] = 32'h00000000; exp_im[2] = 32'hFFFF0000;
        exp_re[3] = 32'hFFFF4AFC; exp_im[3] = 32'hFFFF4AFC;
        exp_re[4] = 32'hFFFF0000; exp_im[4] = 32'h00000000;
        exp_re[5] = 32'hFFFF4AFC; exp_im[5] = 32'h0000B504;
        exp_re[6] = 32'h00000000; exp_im[6] = 32'h00010000;
        exp_re[7] = 32'h0000B504; exp_im[7] = 32'h0000B504;
        compare_bins(8, "delayed");

        fill_x(3);
        model(3, 0);
        send_frame(0, 8, 1'b0, "rand_flow");
        finish_frame(0, 8, 1'b0, 1'b0, 12, "rand_flow");
        compare_bins(8, "rand_flow");
        send_frame(0, 8, 1'b1, "rand_stall");
        finish_frame(0, 8, 1'b1, 1'b1, 12, "rand_stall");
        compare_bins(8, "rand_stall");

        fill_x(3);
        model(3, 1);
        send_frame(1, 8, 1'b1, "rand_scaled");
        finish_frame(1, 8, 1'b1, 1'b1, 12, "rand_scaled");
        compare_bins(8, "rand_scaled");

        fill_x(3);
        send_frame(0, 8, 1'b0, "abort");
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort out_valid", out_valid[0], 1'b0);
        check("abort busy", busy[0], 1'b0);
        check("abort in_ready in reset", in_ready[0], 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort in_ready after release", in_ready[0], 1'b1);
        fill_x(1);
        send_frame(0, 8, 1'b0, "dc_after_abort");
        finish_frame(0, 8, 1'b0, 1'b0, 12, "dc_after_abort");
        dc_expect(8, 32'h80000);
        compare_bins(8, "dc_after_abort");

        send_frame(2, 2, 1'b0, "dc_n2");
        finish_frame(2, 2, 1'b0, 1'b0, 1, "dc_n2");
        dc_expect(2, 32'h20000);
        compare_bins(2, "dc_n2");

        send_frame(3, 64, 1'b0, "dc_n64");
        finish_frame(3, 64, 1'b0, 1'b0, 192, "dc_n64");
        dc_expect(64, 32'h400000);
        compare_bins(64, "dc_n64");

        fill_x(3);
        model(1, 0);
        send_frame(2, 2, 1'b1, "rand_n2");
        finish_frame(2, 2, 1'b1, 1'b1, 1, "rand_n2");
        compare_bins(2, "rand_n2");

        fill_x(3);
        model(6, 0);
        send_frame(3, 64, 1'b1, "rand_n64");
        finish_frame(3, 64, 1'b1, 1'b1, 192, "rand_n64");
        compare_bins(64, "rand_n64");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
